// File: rtl/add_serial_pkg.sv
// Shared definitions for the bit-serial adder feeder: default widths,
// adder latency, feeder FSM encoding and the operand FIFO entry layout.
package add_serial_pkg;

    localparam int ADD_WIDTH = 8;
    localparam int ADD_LAT   = 9;   // 1 load cycle + 8 ADD cycles
    localparam int ADD_TAG_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RELEASE = 3'd4
    } feeder_state_e;

    // Operand FIFO entry for the default configuration, MSB first: {tag, a, b}.
    typedef struct packed {
        logic [ADD_TAG_W-1:0] tag;
        logic [ADD_WIDTH-1:0] a;
        logic [ADD_WIDTH-1:0] b;
    } operand_entry_t;

endpackage

// File: rtl/add_serial_fifo.sv
// Generic synchronous FIFO. Pointers wrap modulo DEPTH; occupancy is tracked
// by an explicit counter, so full/empty never depend on pointer equality.
// Pushes while full and pops while empty are ignored.
module add_serial_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 20,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/add_serial_feeder.sv
// Operand-issue stage for the bit-serial adder. Buffers tagged operand pairs,
// launches one add at a time, waits out the fixed adder latency, captures the
// sum into a valid/ready result register, then releases the adder.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// in_ready depends only on FIFO fullness; res_valid never waits on res_ready,
// and res_sum/res_tag hold while res_valid && !res_ready.
module add_serial_feeder
    import add_serial_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = 2,
    parameter int LAT   = ADD_LAT,
    parameter int TAG_W = ADD_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam int ENTRY_W = TAG_W + 2 * WIDTH;
    localparam int CNT_W   = $clog2(LAT + 1);
    localparam int FCNT_W  = $clog2(DEPTH + 1);

    feeder_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  res_sum_q, res_sum_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;
    logic [TAG_W-1:0]   head_tag;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    assign fifo_din = {in_tag, in_a, in_b};
    assign head_tag = fifo_dout[ENTRY_W-1 -: TAG_W];
    assign head_a   = fifo_dout[2*WIDTH-1 -: WIDTH];
    assign head_b   = fifo_dout[WIDTH-1:0];

    add_serial_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // No bypass: a full FIFO refuses input even in a cycle that pops.
    assign in_ready  = !fifo_full;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_tag   = res_tag_q;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

    // Next-state and outputs of the issue FSM and result register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        tag_d       = tag_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_tag_d   = res_tag_q;
        fifo_pop    = 1'b0;
        add_en      = 1'b0;

        // Consumer takes the result; CAPTURE below may reload it this cycle.
        if (res_valid_q && res_ready) res_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    add_a_d  = head_a;
                    add_b_d  = head_b;
                    tag_d    = head_tag;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                add_en  = 1'b1;
                // Counts RUN cycles so CAPTURE lands LAT cycles after START.
                cnt_d   = CNT_W'(LAT - 2);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == '0) state_d = ST_CAPTURE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_CAPTURE: begin
                // Adder sits in DONE with add_out stable while we wait for room.
                if (!res_valid_q || res_ready) begin
                    res_valid_d = 1'b1;
                    res_sum_d   = add_out;
                    res_tag_d   = tag_q;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                add_en = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    add_a_d  = head_a;
                    add_b_d  = head_b;
                    tag_d    = head_tag;
                    state_d  = ST_START;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_tag_q   <= res_tag_d;
        end
    end

endmodule

// File: tb/tb_add_serial_feeder.sv
// Bench for add_serial_feeder with a behavioural bit-serial adder attached.
module tb_add_serial_feeder;
    import add_serial_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [3:0] in_tag = '0;
    logic [7:0] add_a, add_b, add_out;
    logic       add_en;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_sum;
    logic [3:0] res_tag;
    logic       busy;

    add_serial_feeder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_out(add_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_tag(res_tag),
        .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
    endtask

    // ---------------- adder model ----------------
    // 0 idle, 1 busy, 2 done. Output is junk (~sum) until done.
    logic [1:0] m_state;
    logic [3:0] m_cnt;
    logic [7:0] m_a, m_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 2'd0; m_cnt <= '0; m_a <= '0; m_b <= '0; add_out <= '0;
        end else begin
            case (m_state)
                2'd0: if (add_en) begin
                    m_a <= add_a; m_b <= add_b; m_cnt <= 4'(ADD_LAT - 1);
                    add_out <= ~(add_a + add_b); m_state <= 2'd1;
                end
                2'd1: if (m_cnt == 4'd1) begin
                    add_out <= m_a + m_b; m_state <= 2'd2;
                end else m_cnt <= m_cnt - 4'd1;
                2'd2: if (add_en) m_state <= 2'd0;
                default: m_state <= 2'd0;
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [11:0] exp_q[$];      // {tag, sum}
    int starts[$];
    int last_release_cyc = -1;
    int last_rise_cyc = -1;
    int en_pulses = 0;
    int n_res = 0;
    int proto_err = 0;
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_sum;
    logic [3:0] prev_tag;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (add_en) begin
                en_pulses++;
                if (m_state == 2'd0) starts.push_back(cyc);
                else if (m_state == 2'd2) last_release_cyc = cyc;
                else proto_err++;
            end
            if (m_state != 2'd0 && (add_a != m_a || add_b != m_b)) proto_err++;
            if (prev_stall) begin
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_sum", res_sum, prev_sum);
                chk("hold_tag", res_tag, prev_tag);
            end
            if (res_valid && !prev_valid) last_rise_cyc = cyc;
            if (res_valid && res_ready) begin
                n_res++;
                if (exp_q.size() == 0) chk("unexpected_result", {res_tag, res_sum}, 32'hFFFF_FFFF);
                else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    chk("res_tag", res_tag, e[11:8]);
                    chk("res_sum", res_sum, e[7:0]);
                end
            end
            prev_valid = res_valid && !res_ready;
            prev_stall = res_valid && !res_ready;
            prev_sum   = res_sum;
            prev_tag   = res_tag;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                           input logic [7:0] sum, input bit expect_res);
        int waited = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        while (!in_ready && waited < 300) begin step(1); waited++; end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 1);
        else if (expect_res) exp_q.push_back({t, sum});
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((busy || res_valid || exp_q.size() != 0) && n < 400) begin step(1); n++; end
        chk(name, 32'(busy || res_valid || exp_q.size() != 0), 0);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, 32'(in_ready), 1);
        chk({pfx, "_res_valid"}, 32'(res_valid), 0);
        chk({pfx, "_add_en"}, 32'(add_en), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_add_a"}, add_a, 0);
        chk({pfx, "_add_b"}, add_b, 0);
        chk({pfx, "_res_sum"}, res_sum, 0);
        chk({pfx, "_res_tag"}, res_tag, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s0, r0, waited;

        // Reset
        step(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        step(2);

        // Single op: 0x25 + 0x13 = 0x38, tag 1
        res_ready = 1'b1;
        en_pulses = 0;
        starts.delete();
        push_op(8'h25, 8'h13, 4'd1, 8'h38, 1'b1);
        drain("single_drain");
        chk("single_latency", 32'(last_rise_cyc - starts[0]), 10);
        chk("single_en_pulses", 32'(en_pulses), 2);

        // Wrap-around sums
        push_op(8'hFF, 8'h01, 4'd2, 8'h00, 1'b1);
        push_op(8'h80, 8'h80, 4'd3, 8'h00, 1'b1);
        push_op(8'h7F, 8'h01, 4'd4, 8'h80, 1'b1);
        drain("wrap_drain");

        // Back-to-back, start spacing
        starts.delete();
        push_op(8'h01, 8'h02, 4'd5, 8'h03, 1'b1);
        push_op(8'h10, 8'h20, 4'd6, 8'h30, 1'b1);
        push_op(8'hAA, 8'h55, 4'd7, 8'hFF, 1'b1);
        push_op(8'hF0, 8'h0F, 4'd8, 8'hFF, 1'b1);
        drain("b2b_drain");
        chk("b2b_starts", 32'(starts.size()), 4);
        for (int i = 1; i < 4; i++)
            if (i < starts.size()) chk("b2b_spacing", 32'(starts[i] - starts[i-1]), 11);

        // Backpressure: two ops complete with res_ready low
        res_ready = 1'b0;
        r0 = n_res;
        push_op(8'h11, 8'h22, 4'd9, 8'h33, 1'b1);
        push_op(8'h40, 8'h04, 4'd10, 8'h44, 1'b1);
        step(40);
        chk("bp_valid", 32'(res_valid), 1);
        chk("bp_sum", res_sum, 8'h33);
        chk("bp_tag", res_tag, 4'd9);
        chk("bp_adder_done", 32'(m_state), 2);
        en_pulses = 0;
        step(5);
        chk("bp_no_en", 32'(en_pulses), 0);
        chk("bp_busy", 32'(busy), 1);
        res_ready = 1'b1;
        drain("bp_drain");
        chk("bp_count", 32'(n_res - r0), 2);

        // FIFO full with the FSM busy
        push_op(8'h01, 8'h01, 4'd11, 8'h02, 1'b1);
        push_op(8'h02, 8'h03, 4'd12, 8'h05, 1'b1);
        push_op(8'h10, 8'h10, 4'd13, 8'h20, 1'b1);
        chk("full_ready_low", 32'(in_ready), 0);
        in_valid = 1'b1; in_a = 8'hC0; in_b = 8'h30; in_tag = 4'd14;
        waited = 0;
        while (!in_ready && waited < 300) begin step(1); waited++; end
        chk("full_waited", 32'(waited > 0), 1);
        chk("full_ready_after_pop", 32'(cyc - last_release_cyc), 1);
        if (in_ready) exp_q.push_back({4'd14, 8'hF0});
        step(1);
        in_valid = 1'b0;
        drain("full_drain");

        // Reset in RUN
        r0 = n_res;
        s0 = starts.size();
        push_op(8'h33, 8'h44, 4'd15, 8'h77, 1'b0);
        waited = 0;
        while (starts.size() == s0 && waited < 50) begin step(1); waited++; end
        chk("rr_started", 32'(starts.size() - s0), 1);
        step(4);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rr");
        step(3);
        rst = 1'b0;
        step(2);
        chk("rr_no_result", 32'(n_res - r0), 0);
        chk("rr_idle", 32'(busy), 0);
        push_op(8'h05, 8'h06, 4'd3, 8'h0B, 1'b1);
        drain("rr_drain");
        chk("rr_count", 32'(n_res - r0), 1);

        // Final report
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        chk("adder_protocol", 32'(proto_err), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
